// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Stall/flush sequencer for the 5-stage core. It handles load-use bubbles,
// taken-branch redirects, and data-memory freezes with a timeout guard.
// The control outputs are decoded combinationally from the state and the inputs.
// Defining HAZARD_PERF_CNT_EN adds the stall_cycles and flush_events counters.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_access,
  input  logic                  mem_ready,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_hold,
  output logic                  mem_wb_bubble,
  output logic                  mem_timeout_err,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events,
`endif
  output logic [1:0]            fsm_state
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);

  if (CNT_W < 1 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_param
    $error("pipeline_hazard_controller: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_USE = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  state_t         state_r, state_nxt_s, res_state_s;
  logic [WCW-1:0] wait_cnt_r, wait_cnt_nxt_s;
  logic           err_r, err_nxt_s;
  logic           lu_hz_s;
  logic           pc_we_s, ifid_we_s, ifid_fl_s, idex_fl_s, hold_s, bubble_s;
  logic           res_pc_s, res_we_s, res_ifid_fl_s, res_idex_fl_s;

  assign lu_hz_s = id_ex_mem_read && (id_ex_rd != {REG_ADDR_W{1'b0}}) &&
                   ((if_id_rs1 == id_ex_rd) || (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));

  // Branch / load-use / advance decision used both in RUN and at memory release
  always_comb begin
    res_state_s   = ST_RUN;
    res_pc_s      = 1'b1;
    res_we_s      = 1'b1;
    res_ifid_fl_s = 1'b0;
    res_idex_fl_s = 1'b0;
    if (ex_branch_taken) begin
      res_ifid_fl_s = 1'b1;
      res_idex_fl_s = 1'b1;
      res_state_s   = ST_REDIRECT;
    end else if (lu_hz_s) begin
      res_pc_s      = 1'b0;
      res_we_s      = 1'b0;
      res_idex_fl_s = 1'b1;
      res_state_s   = ST_LOAD_USE;
    end else begin
      res_state_s   = ST_RUN;
    end
  end

  // Next-state and control decode for the current state and inputs
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    err_nxt_s      = err_r;
    pc_we_s        = 1'b1;
    ifid_we_s      = 1'b1;
    ifid_fl_s      = 1'b0;
    idex_fl_s      = 1'b0;
    hold_s         = 1'b0;
    bubble_s       = 1'b0;
    if (!rst_n) begin
      pc_we_s        = 1'b0;
      ifid_we_s      = 1'b0;
      ifid_fl_s      = 1'b1;
      idex_fl_s      = 1'b1;
      bubble_s       = 1'b1;
      state_nxt_s    = ST_RUN;
      wait_cnt_nxt_s = {WCW{1'b0}};
      err_nxt_s      = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_access && !mem_ready) begin
            pc_we_s        = 1'b0;
            ifid_we_s      = 1'b0;
            hold_s         = 1'b1;
            bubble_s       = 1'b1;
            state_nxt_s    = ST_MEM_WAIT;
            wait_cnt_nxt_s = WCW'(1);
          end else begin
            pc_we_s     = res_pc_s;
            ifid_we_s   = res_we_s;
            ifid_fl_s   = res_ifid_fl_s;
            idex_fl_s   = res_idex_fl_s;
            state_nxt_s = res_state_s;
          end
        end
        ST_LOAD_USE: begin
          state_nxt_s = ST_RUN;
        end
        ST_MEM_WAIT: begin
          if (!mem_ready && (wait_cnt_r < TIMEOUT_V)) begin
            pc_we_s        = 1'b0;
            ifid_we_s      = 1'b0;
            hold_s         = 1'b1;
            bubble_s       = 1'b1;
            wait_cnt_nxt_s = wait_cnt_r + WCW'(1);
          end else begin
            pc_we_s        = res_pc_s;
            ifid_we_s      = res_we_s;
            ifid_fl_s      = res_ifid_fl_s;
            idex_fl_s      = res_idex_fl_s;
            state_nxt_s    = res_state_s;
            wait_cnt_nxt_s = {WCW{1'b0}};
            err_nxt_s      = err_r | !mem_ready;
          end
        end
        ST_REDIRECT: begin
          ifid_fl_s   = 1'b1;
          state_nxt_s = ST_RUN;
        end
        default: begin
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = {WCW{1'b0}};
        end
      endcase
    end
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    state_r    <= state_nxt_s;
    wait_cnt_r <= wait_cnt_nxt_s;
    err_r      <= err_nxt_s;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Performance counters: frozen-PC cycles and flush cycles, wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(!pc_we_s);
      flush_cnt_r <= flush_cnt_r + CNT_W'(ifid_fl_s | idex_fl_s);
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_events = flush_cnt_r;
`endif

  assign pc_write_en     = pc_we_s;
  assign if_id_write_en  = ifid_we_s;
  assign if_id_flush     = ifid_fl_s;
  assign id_ex_flush     = idex_fl_s;
  assign ex_mem_hold     = hold_s;
  assign mem_wb_bubble   = bubble_s;
  assign mem_timeout_err = err_r;
  assign fsm_state       = state_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller (MEM_TIMEOUT=4): directed literal
// sequences followed by randomized traffic checked against a rule-level model.
module tb_pipeline_hazard_controller;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] if_id_rs1 = 5'd0, if_id_rs2 = 5'd0, id_ex_rd = 5'd0;
  logic if_id_uses_rs2 = 1'b0, id_ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic mem_access = 1'b0, mem_ready = 1'b0;
  logic pc_write_en, if_id_write_en, if_id_flush, id_ex_flush;
  logic ex_mem_hold, mem_wb_bubble, mem_timeout_err;
  logic [1:0] fsm_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  pipeline_hazard_controller #(.REG_ADDR_W(5), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout_err(mem_timeout_err),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endfunction

  // {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_hold, mem_wb_bubble}
  wire [5:0] outs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_hold, mem_wb_bubble};

  // ---------------- behavioural model (rules, not encodings) ----------------
  bit  valid = 1'b0;
  int  mw = 0;            // cycles already spent frozen on memory (0 = none)
  bit  lu_pend = 1'b0;    // the bubble cycle after a load-use stall is due
  bit  rd_pend = 1'b0;    // the second redirect cycle is due
  bit  m_err = 1'b0;
  int unsigned m_stall = 0, m_flush = 0;

  // Compare process: check outputs against the model, then advance the model
  always @(negedge clk) begin
    logic [5:0] e;
    logic [1:0] ef;
    bit lu, waiting, rel;
    lu = id_ex_mem_read && id_ex_rd != 5'd0 &&
         (if_id_rs1 == id_ex_rd || (if_id_uses_rs2 && if_id_rs2 == id_ex_rd));
    ef = (mw > 0) ? 2'd2 : rd_pend ? 2'd3 : lu_pend ? 2'd1 : 2'd0;
    e = 6'b110000;
    if (!rst_n) begin
      e = 6'b001101;
    end else if (rd_pend) begin
      e = 6'b111000;
    end else if (lu_pend) begin
      e = 6'b110000;
    end else begin
      waiting = (mw > 0);
      rel = waiting && (mem_ready || mw == TO);
      if ((waiting && !rel) || (!waiting && mem_access && !mem_ready)) e = 6'b000011;
      else if (ex_branch_taken) e = 6'b111100;
      else if (lu) e = 6'b000100;
      else e = 6'b110000;
    end
    if (valid) begin
      chk("model_outs", {26'd0, outs}, {26'd0, e});
      chk("model_state", {30'd0, fsm_state}, {30'd0, ef});
      chk("model_err", {31'd0, mem_timeout_err}, {31'd0, m_err});
`ifdef HAZARD_PERF_CNT_EN
      chk("model_stall_cnt", stall_cycles, m_stall);
      chk("model_flush_cnt", flush_events, m_flush);
`endif
    end
    // model update to the post-edge situation
    if (!rst_n) begin
      mw = 0; lu_pend = 0; rd_pend = 0; m_err = 0; m_stall = 0; m_flush = 0;
      valid = 1'b1;
    end else begin
      m_stall += (e[5] ? 0 : 1);
      m_flush += ((e[3] | e[2]) ? 1 : 0);
      if (rd_pend) rd_pend = 0;
      else if (lu_pend) lu_pend = 0;
      else begin
        waiting = (mw > 0);
        rel = waiting && (mem_ready || mw == TO);
        if ((waiting && !rel) || (!waiting && mem_access && !mem_ready)) mw = mw + 1;
        else begin
          if (rel) begin
            if (!mem_ready) m_err = 1;
            mw = 0;
          end
          if (ex_branch_taken) rd_pend = 1;
          else if (lu) lu_pend = 1;
        end
      end
    end
  end

  // One directed cycle: drive after the edge, check hand-computed literals mid-cycle
  task automatic cyc(input logic r, input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic u2, input logic br, input logic ma,
                     input logic rdy, input string nm, input logic [5:0] eo,
                     input logic [1:0] efs, input logic ee);
    @(posedge clk); #1;
    rst_n = r; id_ex_mem_read = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
    if_id_uses_rs2 = u2; ex_branch_taken = br; mem_access = ma; mem_ready = rdy;
    @(negedge clk); #1;
    chk({nm, "_outs"}, {26'd0, outs}, {26'd0, eo});
    chk({nm, "_state"}, {30'd0, fsm_state}, {30'd0, efs});
    chk({nm, "_err"}, {31'd0, mem_timeout_err}, {31'd0, ee});
  endtask

  initial begin
    // reset with hazard and memory stall forced
    cyc(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 0, "rst0", 6'b001101, 2'd0, 0);
    cyc(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 0, "rst1", 6'b001101, 2'd0, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "post_rst", 6'b110000, 2'd0, 0);
    // load-use on rs1
    cyc(1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, "lu_stall", 6'b000100, 2'd0, 0);
    cyc(1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, "lu_bubble", 6'b110000, 2'd1, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "lu_back", 6'b110000, 2'd0, 0);
    cyc(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "lu_rd0", 6'b110000, 2'd0, 0);
    // load-use on rs2, then rs2 match ignored when not used
    cyc(1, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, "lu_rs2", 6'b000100, 2'd0, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "lu_rs2_b", 6'b110000, 2'd1, 0);
    cyc(1, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, "lu_rs2_unused", 6'b110000, 2'd0, 0);
    // taken branch pulse (with a load-use present: branch wins)
    cyc(1, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 0, "br_c0", 6'b111100, 2'd0, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "br_c1", 6'b111000, 2'd3, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "br_c2", 6'b110000, 2'd0, 0);
    // memory access ready immediately: no stall
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, "mem_rdy_now", 6'b110000, 2'd0, 0);
    // memory wait: 3 frozen cycles, release on ready
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "mw0", 6'b000011, 2'd0, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "mw1", 6'b000011, 2'd2, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "mw2", 6'b000011, 2'd2, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, "mw_rel", 6'b110000, 2'd2, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "mw_done", 6'b110000, 2'd0, 0);
    // memory stall with a branch held: branch acted on at release
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, "sb0", 6'b000011, 2'd0, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, "sb1", 6'b000011, 2'd2, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, "sb_rel", 6'b111100, 2'd2, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "sb_redir", 6'b111000, 2'd3, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "sb_done", 6'b110000, 2'd0, 0);
    // timeout: 4 frozen cycles, forced release on the 5th
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "to0", 6'b000011, 2'd0, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "to1", 6'b000011, 2'd2, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "to2", 6'b000011, 2'd2, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "to3", 6'b000011, 2'd2, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "to_rel", 6'b110000, 2'd2, 0);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "to_err", 6'b110000, 2'd0, 1);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, "to_sticky", 6'b110000, 2'd0, 1);
    cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "to_rst", 6'b001101, 2'd0, 1);
    cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "to_cleared", 6'b110000, 2'd0, 0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst_n           = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      id_ex_mem_read  = 1'($urandom_range(0, 1));
      id_ex_rd        = 5'($urandom_range(0, 3));
      if_id_rs1       = 5'($urandom_range(0, 3));
      if_id_rs2       = 5'($urandom_range(0, 3));
      if_id_uses_rs2  = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0;
      mem_access      = ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0;
      mem_ready       = ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0;
    end
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
